// File: rtl/pc_ctrl_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_ctrl_sequencer_pkg
// Brief    : Opcodes, state encoding and decoded-strobe bundle for the sequencer
// Revision : 1.0
// ============================================================================
package pc_ctrl_sequencer_pkg;

  localparam int OPSIZE = 4;

  localparam logic [OPSIZE-1:0] OP_NOP  = 4'h0;
  localparam logic [OPSIZE-1:0] OP_BR   = 4'h1;
  localparam logic [OPSIZE-1:0] OP_BZ   = 4'h2;
  localparam logic [OPSIZE-1:0] OP_JR   = 4'h3;
  localparam logic [OPSIZE-1:0] OP_JAL  = 4'h4;
  localparam logic [OPSIZE-1:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  typedef struct packed {
    logic branch;
    logic jmp;
    logic wren;
    logic halt;
  } strobes_t;

endpackage
`default_nettype wire

// File: rtl/pc_ctrl_sequencer_decode.sv
`default_nettype none
// ============================================================================
// Module   : pc_ctrl_decode
// Brief    : Combinational instruction word -> PC strobe / field decoder
// Revision : 1.0
// ============================================================================
module pc_ctrl_decode
  import pc_ctrl_sequencer_pkg::*;
#(
  parameter int ADDSIZE  = 4,
  parameter int DISPSIZE = 8,
  parameter int INSTSIZE = 16
) (
  input  logic [INSTSIZE-1:0] i_inst,
  input  logic                i_zero,
  output strobes_t            o_strb,
  output logic [DISPSIZE-1:0] o_disp,
  output logic [ADDSIZE-1:0]  o_ra,
  output logic [ADDSIZE-1:0]  o_rw
);

  logic [OPSIZE-1:0] w_op;

  assign w_op   = i_inst[INSTSIZE-1 -: OPSIZE];
  assign o_disp = i_inst[DISPSIZE-1:0];
  assign o_ra   = i_inst[DISPSIZE+ADDSIZE-1 -: ADDSIZE];
  // With the minimum word width the rw field shares its bits with the opcode.
  assign o_rw   = i_inst[ADDSIZE+DISPSIZE+ADDSIZE-1 -: ADDSIZE];

  always_comb begin
    o_strb = '0;
    case (w_op)
      OP_BR:   o_strb.branch = 1'b1;
      OP_BZ:   o_strb.branch = i_zero;
      OP_JR:   o_strb.jmp    = 1'b1;
      OP_JAL: begin
        o_strb.jmp  = 1'b1;
        o_strb.wren = 1'b1;
      end
      OP_HALT: o_strb.halt   = 1'b1;
      default: o_strb        = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_ctrl_sequencer
// Brief    : Fetch/decode/issue sequencer driving the program counter controls
// Revision : 1.0
// ============================================================================
module pc_ctrl_sequencer
  import pc_ctrl_sequencer_pkg::*;
#(
  parameter int ADDSIZE  = 4,
  parameter int DISPSIZE = 8,
  parameter int INSTSIZE = 16,
  parameter int CNTSIZE  = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  input  logic                imem_valid,
  input  logic [INSTSIZE-1:0] imem_data,
  input  logic                zero,
  output logic [DISPSIZE-1:0] disp,
  output logic [ADDSIZE-1:0]  ra,
  output logic [ADDSIZE-1:0]  rw,
  output logic                jmp,
  output logic                branch,
  output logic                wren,
  output logic                clken,
  output logic                halted,
  output logic [CNTSIZE-1:0]  retired
);

  localparam logic [CNTSIZE-1:0] C_ONE = CNTSIZE'(1);

  if (INSTSIZE < OPSIZE + ADDSIZE + DISPSIZE) begin : g_size_check
    $error("pc_ctrl_sequencer: INSTSIZE too small for opcode, ra and disp fields");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [INSTSIZE-1:0] r_inst;

  logic                r_req;
  logic                r_clken;
  logic                r_branch;
  logic                r_jmp;
  logic                r_wren;
  logic                r_halted;
  logic [DISPSIZE-1:0] r_disp;
  logic [ADDSIZE-1:0]  r_ra;
  logic [ADDSIZE-1:0]  r_rw;
  logic [CNTSIZE-1:0]  r_retired;

  logic                w_req_nxt;
  logic                w_clken_nxt;
  logic                w_branch_nxt;
  logic                w_jmp_nxt;
  logic                w_wren_nxt;
  logic                w_halted_nxt;
  logic [DISPSIZE-1:0] w_disp_nxt;
  logic [ADDSIZE-1:0]  w_ra_nxt;
  logic [ADDSIZE-1:0]  w_rw_nxt;
  logic [CNTSIZE-1:0]  w_retired_nxt;

  logic                w_fetch_hit;
  strobes_t            w_dec_strb;
  logic [DISPSIZE-1:0] w_dec_disp;
  logic [ADDSIZE-1:0]  w_dec_ra;
  logic [ADDSIZE-1:0]  w_dec_rw;

  pc_ctrl_decode #(
    .ADDSIZE  (ADDSIZE),
    .DISPSIZE (DISPSIZE),
    .INSTSIZE (INSTSIZE)
  ) u_decode (
    .i_inst (r_inst),
    .i_zero (zero),
    .o_strb (w_dec_strb),
    .o_disp (w_dec_disp),
    .o_ra   (w_dec_ra),
    .o_rw   (w_dec_rw)
  );

  // The request is registered, so the valid handshake is qualified by what
  // memory actually saw this cycle rather than by the state alone.
  assign w_fetch_hit = (r_state == S_FETCH) && r_req && imem_valid;

  always_comb begin
    w_state_nxt  = r_state;
    w_clken_nxt  = 1'b0;
    w_branch_nxt = 1'b0;
    w_jmp_nxt    = 1'b0;
    w_wren_nxt   = 1'b0;
    w_disp_nxt   = '0;
    w_ra_nxt     = '0;
    w_rw_nxt     = '0;
    case (r_state)
      S_FETCH: begin
        if (w_fetch_hit) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_dec_strb.halt) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt  = S_ISSUE;
          w_clken_nxt  = 1'b1;
          w_branch_nxt = w_dec_strb.branch;
          w_jmp_nxt    = w_dec_strb.jmp;
          w_wren_nxt   = w_dec_strb.wren;
          w_disp_nxt   = w_dec_disp;
          w_ra_nxt     = w_dec_ra;
          w_rw_nxt     = w_dec_rw;
        end
      end
      S_ISSUE: w_state_nxt = S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign w_req_nxt     = (w_state_nxt == S_FETCH);
  assign w_halted_nxt  = (w_state_nxt == S_HALT);
  // Counted on leaving ISSUE so a reset during ISSUE never retires it.
  assign w_retired_nxt = (r_state == S_ISSUE) ? (r_retired + C_ONE) : r_retired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst    <= '0;
      r_req     <= 1'b0;
      r_clken   <= 1'b0;
      r_branch  <= 1'b0;
      r_jmp     <= 1'b0;
      r_wren    <= 1'b0;
      r_halted  <= 1'b0;
      r_disp    <= '0;
      r_ra      <= '0;
      r_rw      <= '0;
      r_retired <= '0;
    end else begin
      if (w_fetch_hit) begin
        r_inst <= imem_data;
      end
      r_req     <= w_req_nxt;
      r_clken   <= w_clken_nxt;
      r_branch  <= w_branch_nxt;
      r_jmp     <= w_jmp_nxt;
      r_wren    <= w_wren_nxt;
      r_halted  <= w_halted_nxt;
      r_disp    <= w_disp_nxt;
      r_ra      <= w_ra_nxt;
      r_rw      <= w_rw_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  assign imem_req = r_req;
  assign clken    = r_clken;
  assign branch   = r_branch;
  assign jmp      = r_jmp;
  assign wren     = r_wren;
  assign halted   = r_halted;
  assign disp     = r_disp;
  assign ra       = r_ra;
  assign rw       = r_rw;
  assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_ctrl_sequencer
// Brief    : Self-checking bench: directed table, random instructions, halt/reset
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pc_ctrl_sequencer;

  localparam int ADDSIZE  = 4;
  localparam int DISPSIZE = 8;
  localparam int INSTSIZE = 16;
  localparam int CNTSIZE  = 4;   // small counter so wrap-around is reached

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                imem_req;
  logic                imem_valid = 1'b0;
  logic [INSTSIZE-1:0] imem_data = '0;
  logic                zero = 1'b0;
  logic [DISPSIZE-1:0] disp;
  logic [ADDSIZE-1:0]  ra;
  logic [ADDSIZE-1:0]  rw;
  logic                jmp;
  logic                branch;
  logic                wren;
  logic                clken;
  logic                halted;
  logic [CNTSIZE-1:0]  retired;

  pc_ctrl_sequencer #(
    .ADDSIZE  (ADDSIZE),
    .DISPSIZE (DISPSIZE),
    .INSTSIZE (INSTSIZE),
    .CNTSIZE  (CNTSIZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .zero       (zero),
    .disp       (disp),
    .ra         (ra),
    .rw         (rw),
    .jmp        (jmp),
    .branch     (branch),
    .wren       (wren),
    .clken      (clken),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int exp_ret     = 0;

  typedef struct {
    string       name;
    logic [15:0] inst;
    logic        z;
    int          waits;
    logic        br;
    logic        j;
    logic        wr;
    logic [7:0]  d;
    logic [3:0]  a;
    logic [3:0]  w;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic e_req, input logic e_clken,
                       input logic e_br, input logic e_jmp, input logic e_wren,
                       input logic e_halt, input logic [7:0] e_disp,
                       input logic [3:0] e_ra, input logic [3:0] e_rw, input int e_ret);
    logic [CNTSIZE-1:0] er;
    er = CNTSIZE'(e_ret % (1 << CNTSIZE));
    vectors++;
    if ({imem_req, clken, branch, jmp, wren, halted} !== {e_req, e_clken, e_br, e_jmp, e_wren, e_halt}
        || disp !== e_disp || ra !== e_ra || rw !== e_rw || retired !== er) begin
      miscompares++;
      $display("FAIL %s: got req=%b clken=%b br=%b jmp=%b wren=%b halt=%b disp=%h ra=%h rw=%h ret=%0d; want req=%b clken=%b br=%b jmp=%b wren=%b halt=%b disp=%h ra=%h rw=%h ret=%0d",
               name, imem_req, clken, branch, jmp, wren, halted, disp, ra, rw, retired,
               e_req, e_clken, e_br, e_jmp, e_wren, e_halt, e_disp, e_ra, e_rw, er);
    end
  endtask

  task automatic check_idle(input string name, input logic e_req);
    check(name, e_req, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, exp_ret);
  endtask

  // Entered and left at the negedge of a checked FETCH cycle with imem_req=1.
  task automatic run_inst(input string name, input logic [15:0] inst, input logic z,
                          input int waits, input logic e_br, input logic e_jmp,
                          input logic e_wren, input logic [7:0] e_disp,
                          input logic [3:0] e_ra, input logic [3:0] e_rw);
    for (int k = 0; k < waits; k++) begin
      imem_valid = 1'b0;
      imem_data  = 16'($urandom);
      zero       = 1'($urandom);
      @(negedge clk);
      check_idle({name, "/wait"}, 1'b1);
    end
    imem_valid = 1'b1;
    imem_data  = inst;
    zero       = z;
    @(negedge clk);
    check_idle({name, "/decode"}, 1'b0);
    imem_valid = 1'b1;             // must be ignored while imem_req=0
    imem_data  = 16'($urandom);
    @(negedge clk);
    check(name, 1'b0, 1'b1, e_br, e_jmp, e_wren, 1'b0, e_disp, e_ra, e_rw, exp_ret);
    exp_ret++;
    imem_valid = 1'($urandom);
    imem_data  = 16'($urandom);
    zero       = 1'($urandom);
    @(negedge clk);
    check_idle({name, "/retire"}, 1'b1);
    imem_valid = 1'b0;
  endtask

  function automatic void predict(input logic [15:0] inst, input logic z,
                                  output logic br, output logic j, output logic wr);
    int op;
    op = int'(inst) / 4096;
    br = (op == 1) || (op == 2 && z);
    j  = (op == 3) || (op == 4);
    wr = (op == 4);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"nop0",   16'h0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0};
    tbl[1] = '{"nop1",   16'h0000, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0};
    tbl[2] = '{"br_0f",  16'h100F, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h0F, 4'h0, 4'h1};
    tbl[3] = '{"br_f3",  16'h10F3, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'hF3, 4'h0, 4'h1};
    tbl[4] = '{"bz_z0",  16'h2055, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h55, 4'h0, 4'h2};
    tbl[5] = '{"bz_z1",  16'h2055, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h55, 4'h0, 4'h2};
    tbl[6] = '{"jal",    16'h46A0, 1'b0, 2, 1'b0, 1'b1, 1'b1, 8'hA0, 4'h6, 4'h4};
    tbl[7] = '{"jr",     16'h3400, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h4, 4'h3};
    tbl[8] = '{"rsv7",   16'h7123, 1'b1, 5, 1'b0, 1'b0, 1'b0, 8'h23, 4'h1, 4'h7};
    tbl[9] = '{"rsvE",   16'hE0FF, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'hFF, 4'h0, 4'hE};

    // Reset state, then a valid offered before the first request must not be taken.
    repeat (2) @(negedge clk);
    check("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 0);
    imem_valid = 1'b1;
    imem_data  = 16'h100F;
    rst        = 1'b1;
    @(negedge clk);
    check_idle("first_req", 1'b1);
    imem_valid = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_inst(tbl[i].name, tbl[i].inst, tbl[i].z, tbl[i].waits,
               tbl[i].br, tbl[i].j, tbl[i].wr, tbl[i].d, tbl[i].a, tbl[i].w);
    end

    for (int i = 0; i < 40; i++) begin
      logic [15:0] inst;
      logic        z, br, j, wr;
      inst = {4'($urandom_range(0, 14)), 12'($urandom)};
      z    = 1'($urandom);
      predict(inst, z, br, j, wr);
      run_inst("rand", inst, z, $urandom_range(0, 3), br, j, wr,
               inst[7:0], inst[11:8], inst[15:12]);
    end

    // HALT holds forever regardless of valid, and only reset leaves it.
    imem_valid = 1'b1;
    imem_data  = 16'hF123;
    @(negedge clk);
    check_idle("halt/decode", 1'b0);
    for (int i = 0; i < 6; i++) begin
      imem_valid = 1'($urandom);
      imem_data  = 16'($urandom);
      @(negedge clk);
      check("halt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 4'h0, exp_ret);
    end
    rst = 1'b0;
    #1;
    exp_ret = 0;
    check("halt/reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 0);
    @(negedge clk);
    imem_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    check_idle("halt/fetch", 1'b1);

    // Reset asserted in the middle of a JAL issue cycle.
    run_inst("pre_jal", 16'h0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0);
    imem_valid = 1'b1;
    imem_data  = 16'h46A0;
    zero       = 1'b0;
    @(negedge clk);
    check_idle("rj/decode", 1'b0);
    imem_valid = 1'b0;
    @(negedge clk);
    check("rj/issue", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA0, 4'h6, 4'h4, exp_ret);
    #2 rst = 1'b0;
    #1;
    exp_ret = 0;
    check("rj/async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rj/fetch", 1'b1);
    run_inst("rj/nop", 16'h0000, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
